display_scan: RTL and testbench

DISPLAY_SCAN -- requirements
Module: display_scan

---
 rtl/display_scan.sv | 147 ++++++++++++++
 tb/tb_display_scan.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan.sv
// Six-digit multiplexed 7-segment scanner for a stopwatch display.
// One digit slot lasts DIV cycles. The first BLANK cycles of each slot keep all anodes
// off so the previous digit's pattern cannot ghost onto the next one. All six segment
// inputs are captured together once per frame, so a displayed frame never mixes old
// and new digit values.
module display_scan #(
    parameter int unsigned DIV   = 16667,
    parameter int unsigned BLANK = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       disp_en,
    input  logic       dp_en,
    input  logic [6:0] seg0,
    input  logic [6:0] seg1,
    input  logic [6:0] seg2,
    input  logic [6:0] seg3,
    input  logic [6:0] seg4,
    input  logic [6:0] seg5,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an,
    output logic       frame_tick
);

    localparam int unsigned CW = $clog2(DIV);
    localparam logic [CW-1:0] CntMax = CW'(DIV - 1);
    localparam logic [2:0] IdxMax = 3'd5;

    localparam logic [6:0] SegOff = 7'h7F;
    localparam logic [5:0] AnOff  = 6'h3F;

    // Scan position.
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;

    // Frame snapshot of the six digit patterns; index i holds digit i.
    logic [5:0][6:0] snap_q, snap_d;

    // Registered outputs.
    logic [6:0] seg_q, seg_d;
    logic       dp_q, dp_d;
    logic [5:0] an_q, an_d;
    logic       tick_q, tick_d;

    logic cnt_wrap;
    logic frame_end;
    logic in_blank;

    assign cnt_wrap  = (cnt_q == CntMax);
    assign frame_end = cnt_wrap && (idx_q == IdxMax);
    // Widened compare keeps BLANK = 0 from collapsing to a constant-width special case.
    assign in_blank  = (32'(cnt_q) < BLANK);

    // Next-state for the slot counter, digit index and frame snapshot.
    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        idx_d  = idx_q;
        snap_d = snap_q;
        tick_d = 1'b0;
        if (cnt_wrap) begin
            cnt_d = '0;
            idx_d = (idx_q == IdxMax) ? 3'd0 : idx_q + 3'd1;
        end
        if (frame_end) begin
            snap_d = {seg5, seg4, seg3, seg2, seg1, seg0};
            tick_d = 1'b1;
        end
    end

    // Output decode: one anode low for the current digit, dark during blanking or
    // when the display is disabled. Decimal points sit after the 1 s and 1 min digits.
    always_comb begin
        an_d  = AnOff;
        seg_d = SegOff;
        dp_d  = 1'b1;
        if (disp_en && !in_blank) begin
            unique case (idx_q)
                3'd0: begin
                    an_d  = 6'b111110;
                    seg_d = snap_q[0];
                end
                3'd1: begin
                    an_d  = 6'b111101;
                    seg_d = snap_q[1];
                end
                3'd2: begin
                    an_d  = 6'b111011;
                    seg_d = snap_q[2];
                    dp_d  = ~dp_en;
                end
                3'd3: begin
                    an_d  = 6'b110111;
                    seg_d = snap_q[3];
                end
                3'd4: begin
                    an_d  = 6'b101111;
                    seg_d = snap_q[4];
                    dp_d  = ~dp_en;
                end
                3'd5: begin
                    an_d  = 6'b011111;
                    seg_d = snap_q[5];
                end
                default: begin
                    an_d  = AnOff;
                    seg_d = SegOff;
                    dp_d  = 1'b1;
                end
            endcase
        end
    end

    // Scan position and snapshot registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            idx_q  <= 3'd0;
            snap_q <= {6{SegOff}};
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
        end
    end

    // Output registers; reset forces every anode off immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg_q  <= SegOff;
            dp_q   <= 1'b1;
            an_q   <= AnOff;
            tick_q <= 1'b0;
        end else begin
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            an_q   <= an_d;
            tick_q <= tick_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan with DIV=4, BLANK=1: a time-based reference model checked
// every cycle, plus directed frame captures compared against literal tables.
module tb_display_scan;

    localparam int unsigned DIV   = 4;
    localparam int unsigned BLANK = 1;
    localparam int unsigned FRAME = 6 * DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       disp_en = 1'b1;
    logic       dp_en = 1'b0;
    logic [6:0] seg0, seg1, seg2, seg3, seg4, seg5;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;
    logic       frame_tick;

    display_scan #(
        .DIV   (DIV),
        .BLANK (BLANK)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .disp_en    (disp_en),
        .dp_en      (dp_en),
        .seg0       (seg0),
        .seg1       (seg1),
        .seg2       (seg2),
        .seg3       (seg3),
        .seg4       (seg4),
        .seg5       (seg5),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    logic [6:0] tbl [6]    = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12};
    logic [5:0] an_tbl [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};

    logic [5:0] cap_an [FRAME];
    logic [6:0] cap_seg [FRAME];
    logic       cap_dp [FRAME];
    logic       cap_ft [FRAME];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [6:0] seg_in(input int i);
        case (i)
            0: return seg0;
            1: return seg1;
            2: return seg2;
            3: return seg3;
            4: return seg4;
            default: return seg5;
        endcase
    endfunction

    // Reference model: position follows from the number of edges since reset release.
    int         k_m;
    int         m_cnt;
    int         m_idx;
    logic [6:0] snap_m [6];
    logic [5:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic       exp_ft;
    logic       prev_ft = 1'b0;

    always @(posedge clk) begin
        exp_an  = 6'h3F;
        exp_seg = 7'h7F;
        exp_dp  = 1'b1;
        exp_ft  = 1'b0;
        if (!reset) begin
            k_m = 0;
            for (int i = 0; i < 6; i++) snap_m[i] = 7'h7F;
        end else begin
            m_cnt = k_m % DIV;
            m_idx = (k_m / DIV) % 6;
            if (disp_en && m_cnt >= BLANK) begin
                exp_an  = 6'h3F ^ 6'(1 << m_idx);
                exp_seg = snap_m[m_idx];
                exp_dp  = !(dp_en && (m_idx == 2 || m_idx == 4));
            end
            exp_ft = ((k_m % FRAME) == FRAME - 1);
            if (exp_ft) begin
                for (int i = 0; i < 6; i++) snap_m[i] = seg_in(i);
            end
            k_m++;
        end
        #1;
        check("model_an", an, exp_an);
        check("model_seg", seg, exp_seg);
        check("model_dp", dp, exp_dp);
        check("model_frame_tick", frame_tick, exp_ft);
        check("one_anode_max", $countones(~an) <= 1, 1);
        check("tick_not_double", prev_ft & frame_tick, 0);
        prev_ft = frame_tick;
    end

    task automatic wait_tick();
        bit seen = 1'b0;
        for (int i = 0; i < 4 * FRAME && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = frame_tick;
        end
        check("tick_within_bound", seen, 1);
    endtask

    // Samples one frame starting right after a frame_tick sample.
    task automatic capture_frame(input int chg_at, input int gap_from, input int gap_to);
        for (int j = 0; j < FRAME; j++) begin
            @(posedge clk);
            #1;
            cap_an[j]  = an;
            cap_seg[j] = seg;
            cap_dp[j]  = dp;
            cap_ft[j]  = frame_tick;
            if (j == chg_at) seg3 = 7'h00;
            if (j == gap_from) disp_en = 1'b0;
            if (j == gap_to) disp_en = 1'b1;
        end
        check("tick_period_24", cap_ft[FRAME-1], 1);
    endtask

    task automatic verify_scan(input string tag, input bit dps);
        for (int j = 0; j < FRAME; j++) begin
            if (j % DIV == 0) begin
                check($sformatf("%s_dark_an_%0d", tag, j), cap_an[j], 6'h3F);
                check($sformatf("%s_dark_seg_%0d", tag, j), cap_seg[j], 7'h7F);
            end else begin
                check($sformatf("%s_an_%0d", tag, j), cap_an[j], an_tbl[j / DIV]);
                check($sformatf("%s_seg_%0d", tag, j), cap_seg[j], tbl[j / DIV]);
                check($sformatf("%s_dp_%0d", tag, j), cap_dp[j],
                      (dps && (j / DIV == 2 || j / DIV == 4)) ? 1'b0 : 1'b1);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        seg0 = tbl[0];
        seg1 = tbl[1];
        seg2 = tbl[2];
        seg3 = tbl[3];
        seg4 = tbl[4];
        seg5 = tbl[5];

        repeat (3) @(posedge clk);
        #1;
        check("reset_an", an, 6'h3F);
        check("reset_seg", seg, 7'h7F);
        check("reset_dp", dp, 1'b1);
        check("reset_tick", frame_tick, 1'b0);

        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        check("first_slot_dark_an", an, 6'h3F);
        @(posedge clk);
        #1;
        check("first_lit_an", an, 6'h3E);
        check("first_lit_seg_blank", seg, 7'h7F);

        // Inputs held since before release: frames 1 and 2 show the table.
        wait_tick();
        capture_frame(-1, -1, -1);
        verify_scan("frame1", 1'b0);
        capture_frame(-1, -1, -1);
        verify_scan("frame2", 1'b0);

        dp_en = 1'b1;
        capture_frame(-1, -1, -1);
        verify_scan("dp_on", 1'b1);
        dp_en = 1'b0;

        // seg3 changes during slot 1; old value must persist for the rest of this frame.
        capture_frame(4, -1, -1);
        for (int j = 13; j < 16; j++) check($sformatf("coh_old_seg3_%0d", j), cap_seg[j], 7'h30);
        capture_frame(-1, -1, -1);
        check("coh_dark_12", cap_an[12], 6'h3F);
        for (int j = 13; j < 16; j++) check($sformatf("coh_new_seg3_%0d", j), cap_seg[j], 7'h00);

        // disp_en low for 10 cycles.
        capture_frame(-1, 4, 14);
        check("gap_pre_an", cap_an[3], 6'h3E);
        for (int j = 5; j < 15; j++) begin
            check($sformatf("gap_an_%0d", j), cap_an[j], 6'h3F);
            check($sformatf("gap_seg_%0d", j), cap_seg[j], 7'h7F);
        end
        check("gap_post_an", cap_an[15], 6'h37);
        check("gap_post_seg", cap_seg[15], 7'h00);

        // Reset while digit 3 is lit.
        for (int j = 0; j < 14; j++) begin
            @(posedge clk);
            #1;
        end
        check("midrst_idx3_lit", an, 6'h37);
        #3;
        reset = 1'b0;
        #1;
        check("midrst_an", an, 6'h3F);
        check("midrst_seg", seg, 7'h7F);
        check("midrst_dp", dp, 1'b1);
        check("midrst_tick", frame_tick, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        check("rerel_dark_an", an, 6'h3F);
        @(posedge clk);
        #1;
        check("rerel_first_an", an, 6'h3E);
        check("rerel_first_seg", seg, 7'h7F);

        wait_tick();
        capture_frame(-1, -1, -1);
        check("rerel_snap_seg0", cap_seg[1], 7'h40);
        check("rerel_snap_seg3", cap_seg[13], 7'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
